// File: rtl/clut_pkg.sv
// Shared types and helpers for the CLUT fade controller.
// Holds the sweep FSM state type and the channel-width helper.
package clut_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SCALE,
        S_WRITE,
        S_FINISH
    } state_t;

    // Width of one colour channel (R, G, B equal thirds)
    function automatic int chan_w(input int colrw);
        return colrw / 3;
    endfunction

endpackage

// File: rtl/colr_scale.sv
// Combinational three-channel fade: out = (chan * level) >> chan_w.
// Ports: i_colr base colour, i_level fade level, o_colr scaled colour.
module colr_scale
    import clut_pkg::*;
#(
    parameter int COLRW = 12
) (
    input  logic [COLRW-1:0]   i_colr,
    input  logic [COLRW/3:0]   i_level,
    output logic [COLRW-1:0]   o_colr
);

    localparam int CW = chan_w(COLRW);
    localparam int LW = CW + 1;
    localparam int PW = CW + LW;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [PW-1:0] w_prod;
        assign w_prod = {{LW{1'b0}}, i_colr[g*CW +: CW]}
                      * {{CW{1'b0}}, i_level};
        // level <= 2**CW, so the shifted product always fits CW bits
        assign o_colr[g*CW +: CW] = w_prod[CW +: CW];
    end

endmodule

// File: rtl/clut_fade_ctrl.sv
// Palette fade sweep engine with a host write port sharing the CLUT.
// Ports: clk/rst_n; start/level sweep control; src_addr/src_data base
// palette read; host_req/cidx/colr/ack host write; clut_we/cidx/colr
// CLUT write; busy/done status.
module clut_fade_ctrl
    import clut_pkg::*;
#(
    parameter int COLRW = 12,
    parameter int CIDXW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COLRW/3:0]   level,
    output logic [CIDXW-1:0]   src_addr,
    input  logic [COLRW-1:0]   src_data,
    input  logic               host_req,
    input  logic [CIDXW-1:0]   host_cidx,
    input  logic [COLRW-1:0]   host_colr,
    output logic               host_ack,
    output logic               clut_we,
    output logic [CIDXW-1:0]   clut_cidx,
    output logic [COLRW-1:0]   clut_colr,
    output logic               busy,
    output logic               done
);

    localparam int CW = chan_w(COLRW);
    localparam logic [CW:0]       LVL_MAX  = {1'b1, {CW{1'b0}}};
    localparam logic [CIDXW-1:0]  IDX_LAST = {CIDXW{1'b1}};

    state_t             r_state;
    state_t             w_next;
    logic [CIDXW-1:0]   r_idx;
    logic [CW:0]        r_level;
    logic [COLRW-1:0]   r_scaled;
    logic [CIDXW-1:0]   r_src_addr;
    logic               r_clut_we;
    logic [CIDXW-1:0]   r_clut_cidx;
    logic [COLRW-1:0]   r_clut_colr;
    logic               r_host_ack;
    logic               r_done;
    logic               w_busy;
    logic               w_host_gnt;
    logic               w_fade_gnt;
    logic               w_last;
    logic [CW:0]        w_lvl_clamp;
    logic [COLRW-1:0]   w_scaled;

    colr_scale #(
        .COLRW   (COLRW)
    ) u_scale (
        .i_colr  (src_data),
        .i_level (r_level),
        .o_colr  (w_scaled)
    );

    // A host request arriving while its previous ack is showing is the
    // same request still held; ignoring it avoids a double write.
    assign w_host_gnt  = host_req & ~r_host_ack;
    assign w_fade_gnt  = (r_state == S_WRITE) & ~w_host_gnt;
    assign w_last      = (r_idx == IDX_LAST);
    assign w_lvl_clamp = (level > LVL_MAX) ? LVL_MAX : level;

    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) w_next = S_FETCH;
            end
            S_FETCH:  w_next = S_SCALE;
            S_SCALE:  w_next = S_WRITE;
            S_WRITE: begin
                if (w_fade_gnt) w_next = w_last ? S_FINISH : S_FETCH;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // src_addr is loaded on entry to FETCH so data lands during SCALE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_level    <= '0;
            r_scaled   <= '0;
            r_src_addr <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_idx      <= '0;
                r_level    <= w_lvl_clamp;
                r_src_addr <= '0;
            end
            if (r_state == S_SCALE) r_scaled <= w_scaled;
            if (w_fade_gnt && !w_last) begin
                r_idx      <= r_idx + CIDXW'(1);
                r_src_addr <= r_idx + CIDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clut_we   <= 1'b0;
            r_clut_cidx <= '0;
            r_clut_colr <= '0;
            r_host_ack  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_clut_we  <= w_host_gnt | w_fade_gnt;
            r_host_ack <= w_host_gnt;
            r_done     <= (r_state == S_FINISH);
            if (w_host_gnt) begin
                r_clut_cidx <= host_cidx;
                r_clut_colr <= host_colr;
            end else if (w_fade_gnt) begin
                r_clut_cidx <= r_idx;
                r_clut_colr <= r_scaled;
            end
        end
    end

    assign src_addr  = r_src_addr;
    assign host_ack  = r_host_ack;
    assign clut_we   = r_clut_we;
    assign clut_cidx = r_clut_cidx;
    assign clut_colr = r_clut_colr;
    assign busy      = w_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_clut_fade_ctrl.sv
// Directed bench for clut_fade_ctrl: sweeps, scaling, host arbitration,
// async reset mid-sweep.
module tb_clut_fade_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  level = '0;
    logic [3:0]  src_addr;
    logic [11:0] src_data = '0;
    logic        host_req = 1'b0;
    logic [3:0]  host_cidx = '0;
    logic [11:0] host_colr = '0;
    logic        host_ack;
    logic        clut_we;
    logic [3:0]  clut_cidx;
    logic [11:0] clut_colr;
    logic        busy;
    logic        done;

    clut_fade_ctrl #(.COLRW(12), .CIDXW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .level     (level),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .host_req  (host_req),
        .host_cidx (host_cidx),
        .host_colr (host_colr),
        .host_ack  (host_ack),
        .clut_we   (clut_we),
        .clut_cidx (clut_cidx),
        .clut_colr (clut_colr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [11:0] pal [16];
    logic [11:0] clut_m [16];
    always @(posedge clk) src_data <= pal[src_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0h want %0h", tag, got, exp);
    endtask

    int epoch = 0;
    int t0 = 0;
    logic [11:0] exp_colr = '0;

    int seen = -1;
    int fade_cnt, exp_idx, order_err, colr_err;
    int first_at, last_at, done_at, done_cnt;
    int ack_cnt, consec, host_at, f3_at;
    logic prev_ack = 1'b0;

    always @(negedge clk) begin
        if (epoch != seen) begin
            seen = epoch;
            fade_cnt = 0; exp_idx = 0; order_err = 0; colr_err = 0;
            first_at = -1; last_at = -1; done_at = -1; done_cnt = 0;
            ack_cnt = 0; consec = 0; host_at = -1; f3_at = -1;
        end
        if (rst_n) begin
            if (clut_we) begin
                clut_m[clut_cidx] = clut_colr;
                if (host_ack) begin
                    host_at = cyc - t0;
                end else begin
                    if (int'(clut_cidx) != exp_idx) order_err++;
                    if (clut_colr != exp_colr) colr_err++;
                    if (clut_cidx == 4'd3) f3_at = cyc - t0;
                    if (fade_cnt == 0) first_at = cyc - t0;
                    last_at = cyc - t0;
                    fade_cnt++;
                    exp_idx++;
                end
            end
            if (host_ack) ack_cnt++;
            if (host_ack && prev_ack) consec++;
            if (done) begin
                done_cnt++;
                done_at = cyc - t0;
            end
        end
        prev_ack = host_ack;
    end

    task automatic fill_pal(input logic [11:0] v);
        for (int i = 0; i < 16; i++) pal[i] = v;
    endtask

    // Called at a negedge; the next rising edge accepts start
    task automatic start_sweep(input logic [4:0] lvl);
        level = lvl;
        start = 1'b1;
        epoch++;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, int'(done_cnt != 0), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rel(input int d);
        int n = 0;
        while (cyc - t0 < d && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        fill_pal(12'h000);
        for (int i = 0; i < 16; i++) clut_m[i] = 12'h000;

        // reset state, then start on the first edge after release
        repeat (3) @(negedge clk);
        check("rst_ctl", int'({busy, done, clut_we, host_ack}), 0);
        check("rst_cidx", int'(clut_cidx), 0);
        check("rst_colr", int'(clut_colr), 0);
        check("rst_src", int'(src_addr), 0);

        fill_pal(12'hFFF);
        exp_colr = 12'hFFF;
        rst_n = 1'b1;
        start_sweep(5'd16);
        check("sw_busy", int'(busy), 1);
        wait_done("sw");
        check("sw_cnt", fade_cnt, 16);
        check("sw_order", order_err, 0);
        check("sw_colr", colr_err, 0);
        check("sw_first", first_at, 3);
        check("sw_last", last_at, 48);
        check("sw_done_at", done_at, 49);
        check("sw_done_n", done_cnt, 1);
        check("sw_idle", int'(busy), 0);

        // distinct entries prove the address/cidx pairing
        for (int i = 0; i < 16; i++) pal[i] = {i[3:0], i[3:0], i[3:0]};
        start_sweep(5'd16);
        wait_done("id");
        begin
            int bad = 0;
            for (int i = 0; i < 16; i++)
                if (clut_m[i] != {i[3:0], i[3:0], i[3:0]}) bad++;
            check("id_entries", bad, 0);
        end

        fill_pal(12'hF84);
        exp_colr = 12'h742;
        start_sweep(5'd8);
        wait_done("l8");
        check("l8_colr", colr_err, 0);
        check("l8_cnt", fade_cnt, 16);

        exp_colr = 12'h000;
        start_sweep(5'd0);
        wait_done("l0");
        check("l0_colr", colr_err, 0);

        exp_colr = 12'hF84;
        start_sweep(5'd20);
        wait_done("l20");
        check("l20_colr", colr_err, 0);

        // restart and level change mid-sweep are ignored
        exp_colr = 12'h742;
        start_sweep(5'd8);
        wait_rel(10);
        level = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ms");
        check("ms_cnt", fade_cnt, 16);
        check("ms_colr", colr_err, 0);
        check("ms_done_n", done_cnt, 1);

        // host collides with fade WRITE of idx 3
        fill_pal(12'h123);
        exp_colr = 12'h123;
        start_sweep(5'd16);
        wait_rel(11);
        host_req = 1'b1;
        host_cidx = 4'd3;
        host_colr = 12'hABC;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!host_ack && n < 8);
            check("co_ack_seen", int'(host_ack), 1);
        end
        host_req = 1'b0;
        wait_done("co");
        check("co_ack_n", ack_cnt, 1);
        check("co_host_at", host_at, 12);
        check("co_fade3_at", f3_at, 13);
        check("co_entry3", int'(clut_m[3]), 12'h123);
        check("co_cnt", fade_cnt, 16);
        check("co_order", order_err, 0);
        check("co_done_at", done_at, 50);

        // host request held for 4 cycles while idle
        epoch++;
        t0 = cyc + 1;
        @(negedge clk);
        host_req = 1'b1;
        host_cidx = 4'd9;
        host_colr = 12'h5A5;
        repeat (4) @(negedge clk);
        host_req = 1'b0;
        repeat (3) @(negedge clk);
        check("hb_ack_n", ack_cnt, 2);
        check("hb_consec", consec, 0);
        check("hb_entry9", int'(clut_m[9]), 12'h5A5);

        // async reset while fetching idx 7
        fill_pal(12'h9C3);
        exp_colr = 12'h9C3;
        start_sweep(5'd16);
        wait_rel(21);
        #2 rst_n = 1'b0;
        #1;
        check("ar_ctl", int'({busy, done, clut_we, host_ack}), 0);
        check("ar_src", int'(src_addr), 0);
        check("ar_cidx", int'(clut_cidx), 0);
        check("ar_colr", int'(clut_colr), 0);
        check("ar_cnt", fade_cnt, 7);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("ar_quiet_cnt", fade_cnt, 7);
        check("ar_quiet_done", done_cnt, 0);
        start_sweep(5'd16);
        wait_done("rs");
        check("rs_cnt", fade_cnt, 16);
        check("rs_order", order_err, 0);
        check("rs_first", first_at, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
